fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
- Parametrised synchronous FIFO with guarded write/read, occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe and sticky overflow/underflow error flags.
- Single clock domain.
- Used as the general buffering element between streaming producers and consumers in the datapath, such as the wide 512-bit memory/bus paths.

Parameters:
- DATA_WIDTH, 512, word width in bits.
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..16.
- AFULL_THRESH, 2**ADDR_WIDTH-4, o_afull asserted when count >= this; legal range 1..DEPTH.
- AEMPTY_THRESH, 4, o_aempty asserted when count <= this; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wen  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- i_ren  in  1  read request.
- o_data  out  DATA_WIDTH  read data.
- o_valid  out  1  o_data holds a freshly popped word.
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_aempty  out  1  count <= AEMPTY_THRESH.
- o_afull  out  1  count >= AFULL_THRESH.
- o_count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a write was rejected.
- o_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (i_rst high at a clock edge) sets the following; memory contents are not cleared:
  - pointers = 0, o_count = 0, o_data = 0, o_valid = 0
  - o_empty = 1, o_full = 0, o_aempty = 1, o_afull = 0
  - o_overflow = 0, o_underflow = 0
- Reset mid-operation discards all stored words. Requests in the reset cycle are ignored and do not set the error flags.
- Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2**(ADDR_WIDTH+1). The MSB distinguishes full from empty. o_count = wr_ptr - rd_ptr, truncated to ADDR_WIDTH+1 bits.
- Read acceptance: rd_acc = i_ren & !o_empty.
  - A write in the same cycle does not make an empty FIFO readable.
- Write acceptance: wr_acc = i_wen & (!o_full | rd_acc).
  - When full, a simultaneous accepted read frees the slot, so the write is accepted.
- Accepted write: mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_data; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Rejected write (i_wen & !wr_acc): no state change except o_overflow <= 1, which holds until reset.
- Rejected read (i_ren & !rd_acc): o_underflow <= 1, which holds until reset. o_valid = 0 next cycle; o_data holds its value.
- Count update per cycle:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither occur
- All status flags are combinational from the registered pointers. They reflect post-edge state, i.e. they update one cycle after the request.
- Read latency (default mode) is 1 cycle:
  - after rd_acc at edge N, o_data = popped word and o_valid = 1 during cycle N+1;
  - o_valid = 0 in any cycle following no accepted read;
  - o_data holds its last value.
- Back-to-back reads give one word per cycle, in FIFO order.
- Wrap-around: writes continue indefinitely across pointer wrap with no loss of ordering.

Optional Feature:
- Macro: FIFO_SYNC_FWFT_EN.
- Defined (first-word fall-through):
  - o_data = mem[rd_ptr[ADDR_WIDTH-1:0]], combinational read;
  - o_valid = !o_empty;
  - i_ren acknowledges (pops) the currently shown word.
  - o_data is don't-care while o_empty.
  - Read latency is 0; all acceptance and flag rules are unchanged.
- Undefined: registered 1-cycle read as above.

Decomposition:
- Package fifo_pkg:
  - function ptr_width(addr_width) = addr_width+1;
  - localparam DEPTH derivation;
  - threshold legality check function, used in an elaboration-time assertion.
- One natural sub-module, fifo_sync_ram: a simple dual-port array with write port and read address. Its output is registered or combinational, selected by a parameter driven from the FWFT macro.
- Pointer, count and flag logic stay in the top.

Test Plan:
- Fill/drain, ADDR_WIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=1. Write 8 words 0x1..0x8 then read 8.
  - Flags: o_afull rises at count 6; o_full at 8; o_aempty high at counts 0-1.
  - Reads return 0x1..0x8 each 1 cycle after rd_acc; o_empty returns to 1.
- Overflow: fill 8 words, write 0xFF with i_ren=0.
  - o_overflow=1 next cycle, o_count stays 8.
  - Draining 8 words yields 0x1..0x8; 0xFF is never returned.
- Underflow: read while empty.
  - o_underflow=1, o_valid=0, o_count=0.
  - Simultaneous i_wen and i_ren on empty: write accepted, count=1, o_valid=0.
- Full with simultaneous read+write: with count=8, assert i_wen (0xAA) and i_ren together.
  - Both accepted, count stays 8, no overflow; 0xAA is read out last.
- Wrap and reset: 100 interleaved random push/pop cycles, checked against a scoreboard model.
  - Assert i_rst mid-stream with count=5: next cycle count=0, o_empty=1, sticky flags cleared, o_valid=0.
- FWFT build (FIFO_SYNC_FWFT_EN): write 0x11, 0x22.
  - o_valid=1 and o_data=0x11 the cycle after the first write.
  - Pulse i_ren: o_data=0x22 the next cycle; a second pop gives o_empty=1, o_valid=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the synchronous flag FIFO.
package fifo_pkg;

    localparam int unsigned ADDR_WIDTH_MIN     = 2;
    localparam int unsigned ADDR_WIDTH_MAX     = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    // Extra MSB on the pointers separates full from empty.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    localparam int unsigned DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

    function automatic bit thresh_ok(input int unsigned addr_width,
                                     input int unsigned afull_thresh,
                                     input int unsigned aempty_thresh);
        int unsigned depth;
        depth = depth_of(addr_width);
        return (addr_width >= ADDR_WIDTH_MIN) && (addr_width <= ADDR_WIDTH_MAX) &&
               (afull_thresh >= 1) && (afull_thresh <= depth) &&
               (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Write/read handshake and status bundle of the synchronous flag FIFO.
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned PW = ptr_width(ADDR_WIDTH);

    logic                  i_wen;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_ren;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_aempty;
    logic                  o_afull;
    logic [PW-1:0]         o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    // Producer/consumer side.
    modport master (
        output i_wen, i_data, i_ren,
        input  o_data, o_valid, o_empty, o_full, o_aempty, o_afull,
               o_count, o_overflow, o_underflow
    );

    // FIFO side.
    modport slave (
        input  i_wen, i_data, i_ren,
        output o_data, o_valid, o_empty, o_full, o_aempty, o_afull,
               o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage array; read port registered (REG_OUT=1) or combinational.
module fifo_sync_ram #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter bit          REG_OUT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [DATA_WIDTH-1:0] rdata_q;

        // Output register only loads on a pop, otherwise holds the last word.
        always_ff @(posedge clk) begin
            if (i_rst) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata = rdata_q;
    end else begin : g_comb_out
        logic unused_ok;
        assign unused_ok = ^{i_rst, re};
        assign rdata     = mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy, almost-full/empty flags, read-valid and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned AFULL_THRESH  = (32'(1) << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic              clk,
    input  logic              i_rst,
    fifo_sync_flags_if.slave  bus
);
    localparam int unsigned PW    = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

`ifdef FIFO_SYNC_FWFT_EN
    localparam bit REG_OUT = 1'b0;
`else
    localparam bit REG_OUT = 1'b1;
`endif

    if (!thresh_ok(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_err
        $error("fifo_sync_flags: illegal ADDR_WIDTH or threshold parameters");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_c;
    logic          empty_c;
    logic          full_c;
    logic          rd_acc_c;
    logic          wr_acc_c;
    logic          overflow_q;
    logic          underflow_q;

    // Status is derived purely from the registered pointers.
    assign count_c = wr_ptr - rd_ptr;
    assign empty_c = (count_c == '0);
    assign full_c  = (count_c == PW'(DEPTH));

    // A same-cycle write never makes an empty FIFO readable; a pop frees a full slot.
    assign rd_acc_c = bus.i_ren & ~empty_c;
    assign wr_acc_c = bus.i_wen & (~full_c | rd_acc_c);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (bus.i_wen & ~wr_acc_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.i_ren & ~rd_acc_c) begin
                underflow_q <= 1'b1;
            end
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_OUT    (REG_OUT)
    ) u_ram (
        .clk   (clk),
        .i_rst (i_rst),
        .we    (wr_acc_c),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.i_data),
        .re    (rd_acc_c),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (bus.o_data)
    );

`ifdef FIFO_SYNC_FWFT_EN
    assign bus.o_valid = ~empty_c;
`else
    logic valid_q;

    // Valid marks the cycle right after an accepted pop.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc_c;
        end
    end

    assign bus.o_valid = valid_q;
`endif

    assign bus.o_empty     = empty_c;
    assign bus.o_full      = full_c;
    assign bus.o_aempty    = (count_c <= PW'(AEMPTY_THRESH));
    assign bus.o_afull     = (count_c >= PW'(AFULL_THRESH));
    assign bus.o_count     = count_c;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed/scoreboard bench for fifo_sync_flags at depth 8 (AFULL=6, AEMPTY=1).
module tb_fifo_sync_flags;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic i_rst;
    int   n_checks;
    int   n_fail;

    fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_sync_flags #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (6),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given request; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        bus.i_wen  = w;
        bus.i_data = d;
        bus.i_ren  = r;
        @(posedge clk);
        #1;
        bus.i_wen  = 1'b0;
        bus.i_ren  = 1'b0;
    endtask

    task automatic do_reset(input logic w, input logic r);
        i_rst      = 1'b1;
        bus.i_wen  = w;
        bus.i_data = 16'hDEAD;
        bus.i_ren  = r;
        @(posedge clk);
        #1;
        i_rst     = 1'b0;
        bus.i_wen = 1'b0;
        bus.i_ren = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_count"}, 32'(bus.o_count), 0);
        check({pfx, "_empty"}, 32'(bus.o_empty), 1);
        check({pfx, "_full"}, 32'(bus.o_full), 0);
        check({pfx, "_aempty"}, 32'(bus.o_aempty), 1);
        check({pfx, "_afull"}, 32'(bus.o_afull), 0);
        check({pfx, "_valid"}, 32'(bus.o_valid), 0);
        check({pfx, "_ovf"}, 32'(bus.o_overflow), 0);
        check({pfx, "_udf"}, 32'(bus.o_underflow), 0);
    endtask

`ifndef FIFO_SYNC_FWFT_EN
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_data;
    logic          m_ovf;
    logic          m_udf;

    // Scoreboard-tracked cycle: model decides acceptance, DUT is compared after the edge.
    task automatic sb_cyc(input logic w, input logic [DW-1:0] d, input logic r);
        logic rd;
        logic wr;
        rd = r && (q.size() != 0);
        wr = w && ((q.size() != DEPTH) || rd);
        if (rd) m_data = q.pop_front();
        if (wr) q.push_back(d);
        if (w && !wr) m_ovf = 1'b1;
        if (r && !rd) m_udf = 1'b1;
        cyc(w, d, r);
        check("sb_count", 32'(bus.o_count), 32'(q.size()));
        check("sb_valid", 32'(bus.o_valid), 32'(rd));
        check("sb_data", 32'(bus.o_data), 32'(m_data));
        check("sb_ovf", 32'(bus.o_overflow), 32'(m_ovf));
        check("sb_udf", 32'(bus.o_underflow), 32'(m_udf));
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        i_rst      = 1'b1;
        bus.i_wen  = 1'b0;
        bus.i_ren  = 1'b0;
        bus.i_data = '0;
        do_reset(1'b0, 1'b0);
        check_reset_state("rst");
        check("rst_data", 32'(bus.o_data), 0);

`ifdef FIFO_SYNC_FWFT_EN
        cyc(1'b1, 16'h0011, 1'b0);
        check("fwft_valid1", 32'(bus.o_valid), 1);
        check("fwft_data1", 32'(bus.o_data), 32'h11);
        cyc(1'b1, 16'h0022, 1'b0);
        check("fwft_data1_hold", 32'(bus.o_data), 32'h11);
        check("fwft_count2", 32'(bus.o_count), 2);
        cyc(1'b0, 16'h0, 1'b1);
        check("fwft_data2", 32'(bus.o_data), 32'h22);
        check("fwft_valid2", 32'(bus.o_valid), 1);
        cyc(1'b0, 16'h0, 1'b1);
        check("fwft_empty", 32'(bus.o_empty), 1);
        check("fwft_valid_lo", 32'(bus.o_valid), 0);
        check("fwft_udf", 32'(bus.o_underflow), 0);
`else
        // Fill/drain with flag thresholds.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            check("fill_count", 32'(bus.o_count), 32'(i));
            check("fill_afull", 32'(bus.o_afull), 32'(i >= 6));
            check("fill_full", 32'(bus.o_full), 32'(i == 8));
            check("fill_aempty", 32'(bus.o_aempty), 32'(i <= 1));
            check("fill_empty", 32'(bus.o_empty), 0);
            check("fill_valid", 32'(bus.o_valid), 0);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("drain_data", 32'(bus.o_data), 32'(k));
            check("drain_valid", 32'(bus.o_valid), 1);
            check("drain_count", 32'(bus.o_count), 32'(8 - k));
            check("drain_aempty", 32'(bus.o_aempty), 32'((8 - k) <= 1));
            check("drain_afull", 32'(bus.o_afull), 32'((8 - k) >= 6));
            check("drain_empty", 32'(bus.o_empty), 32'(k == 8));
        end
        cyc(1'b0, '0, 1'b0);
        check("idle_valid", 32'(bus.o_valid), 0);
        check("idle_data_hold", 32'(bus.o_data), 8);

        // Overflow: rejected write leaves contents intact.
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0);
        cyc(1'b1, 16'h00FF, 1'b0);
        check("ovf_flag", 32'(bus.o_overflow), 1);
        check("ovf_count", 32'(bus.o_count), 8);
        check("ovf_full", 32'(bus.o_full), 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("ovf_drain", 32'(bus.o_data), 32'(k));
        end
        check("ovf_sticky", 32'(bus.o_overflow), 1);
        check("ovf_no_udf", 32'(bus.o_underflow), 0);

        // Underflow and write+read on empty.
        cyc(1'b0, '0, 1'b1);
        check("udf_flag", 32'(bus.o_underflow), 1);
        check("udf_valid", 32'(bus.o_valid), 0);
        check("udf_count", 32'(bus.o_count), 0);
        check("udf_data_hold", 32'(bus.o_data), 8);
        cyc(1'b1, 16'h0055, 1'b1);
        check("wr_rd_empty_count", 32'(bus.o_count), 1);
        check("wr_rd_empty_valid", 32'(bus.o_valid), 0);
        cyc(1'b0, '0, 1'b1);
        check("wr_rd_empty_data", 32'(bus.o_data), 32'h55);
        check("wr_rd_empty_valid2", 32'(bus.o_valid), 1);

        // Full with simultaneous read and write.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(16'h10 + i), 1'b0);
        cyc(1'b1, 16'h00AA, 1'b1);
        check("full_rw_count", 32'(bus.o_count), 8);
        check("full_rw_ovf", 32'(bus.o_overflow), 0);
        check("full_rw_data", 32'(bus.o_data), 32'h10);
        check("full_rw_valid", 32'(bus.o_valid), 1);
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, '0, 1'b1);
            check("full_rw_drain", 32'(bus.o_data), 32'(16'h10 + k));
        end
        cyc(1'b0, '0, 1'b1);
        check("full_rw_last", 32'(bus.o_data), 32'hAA);
        check("full_rw_empty", 32'(bus.o_empty), 1);

        // Random push/pop across pointer wrap against the scoreboard.
        do_reset(1'b0, 1'b0);
        q.delete();
        m_data = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        for (int n = 0; n < 100; n++) begin
            sb_cyc(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45));
        end

        // Force both sticky flags, land on count 5 with a pop, then reset mid-stream.
        while (q.size() != 0) sb_cyc(1'b0, '0, 1'b1);
        sb_cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) sb_cyc(1'b1, DW'(16'h100 + i), 1'b0);
        sb_cyc(1'b1, 16'h00EE, 1'b0);
        for (int i = 0; i < 3; i++) sb_cyc(1'b0, '0, 1'b1);
        check("pre_rst_count", 32'(bus.o_count), 5);
        check("pre_rst_valid", 32'(bus.o_valid), 1);
        do_reset(1'b1, 1'b1);
        check_reset_state("mid_rst");
        check("mid_rst_data", 32'(bus.o_data), 0);
        cyc(1'b0, '0, 1'b0);
        check("post_rst_count", 32'(bus.o_count), 0);
        check("post_rst_ovf", 32'(bus.o_overflow), 0);
        cyc(1'b1, 16'h0033, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("post_rst_data", 32'(bus.o_data), 32'h33);
        check("post_rst_empty", 32'(bus.o_empty), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
